// File: rtl/physics_pkg.sv
// Shared types and field helpers for the fighter motion engine.
// Positions and sizes pack two 16-bit fields into one 32-bit word.
package physics_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INTEGRATE,
        S_SETTLE,
        S_RESOLVE
    } state_t;

    localparam int COLL_L = 3;
    localparam int COLL_R = 2;
    localparam int COLL_B = 1;
    localparam int COLL_T = 0;

    localparam int VEL_W = 8;
    localparam int POS_W = 16;

    function automatic logic [POS_W-1:0] hi_field(input logic [31:0] v);
        return v[31:16];
    endfunction

    function automatic logic [POS_W-1:0] lo_field(input logic [31:0] v);
        return v[15:0];
    endfunction

endpackage

// File: rtl/physics_axis.sv
// One axis of motion: signed velocity added to an unsigned position,
// clamped into [lo, hi], optionally killing velocity at the low bound.
module physics_axis
    import physics_pkg::*;
(
    input  logic [POS_W-1:0]        pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic signed [17:0]      lo,
    input  logic signed [17:0]      hi,
    input  logic                    zero_on_lo,
    output logic [POS_W-1:0]        result,
    output logic signed [VEL_W-1:0] vel_out
);

    logic signed [17:0] sum;

    // 18 bits so a full-range position plus velocity cannot wrap
    assign sum = $signed({2'b00, pos}) + $signed({{10{vel[VEL_W-1]}}, vel});

    always_comb begin
        result  = sum[POS_W-1:0];
        vel_out = vel;
        if (sum < lo) begin
            result = lo[POS_W-1:0];
            if (zero_on_lo)
                vel_out = '0;
        end else if (sum > hi) begin
            result = hi[POS_W-1:0];
        end
    end

endmodule

// File: rtl/character_physics.sv
// Per-frame fighter motion: integrate controls and gravity, wait for the
// collision block to see the candidate position, then resolve contacts.
module character_physics
    import physics_pkg::*;
#(
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8,
    parameter int JUMP_VEL  = 10,
    parameter int RUN_SPEED = 3,
    parameter int MAX_JUMPS = 2,
    parameter int SPAWN_X   = 300,
    parameter int SPAWN_Y   = 100,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump_btn,
    input  logic [31:0] char_size,
    input  logic [31:0] stage_pos,
    input  logic [3:0]  coll,
    output logic [31:0] char_pos,
    output logic [7:0]  vel_x,
    output logic [7:0]  vel_y,
    output logic        grounded,
    output logic        update_done,
    output logic        ko,
    output logic        overrun
);

    localparam logic signed [7:0] GRAV_V = 8'(GRAVITY);
    localparam logic signed [7:0] FALL_V = 8'(MAX_FALL);
    localparam logic signed [7:0] JUMP_V = 8'(JUMP_VEL);
    localparam logic signed [7:0] RUN_V  = 8'(RUN_SPEED);
    localparam logic [1:0]  JMAX  = 2'(MAX_JUMPS);
    localparam logic [15:0] SPX   = 16'(SPAWN_X);
    localparam logic [15:0] SPY   = 16'(SPAWN_Y);
    localparam logic [15:0] SCR_H = 16'(SCREEN_H);

    state_t state, next_state;

    logic [15:0] x_q, y_q, px_q, py_q;
    logic signed [7:0] vx_q, vy_q;
    logic [1:0] jumps_left;
    logic grounded_q;
    logic left_q, right_q, jreq_q;
    logic jump_d, jump_pend, jump_rise;

    logic signed [7:0] int_vx, int_vy, ax_vel, ay_vel;
    logic [15:0] ax_res, ay_res;
    logic signed [17:0] x_span, x_hi;
    logic jump_ok;
    logic land, hit_top, side, is_ko;
    logic unused_stage_x;

    assign unused_stage_x = ^hi_field(stage_pos);
    assign jump_rise = jump_btn & ~jump_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (frame_tick) next_state = S_INTEGRATE;
            S_INTEGRATE: next_state = S_SETTLE;
            S_SETTLE:    next_state = S_RESOLVE;
            S_RESOLVE:   next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        int_vx = '0;
        if (left_q && !right_q)
            int_vx = -RUN_V;
        else if (right_q && !left_q)
            int_vx = RUN_V;
        jump_ok = jreq_q && (jumps_left != 2'd0);
        int_vy  = vy_q;
        if (jump_ok)
            int_vy = -JUMP_V;
        else if (!grounded_q)
            int_vy = (vy_q >= FALL_V - GRAV_V) ? FALL_V : vy_q + GRAV_V;
    end

    // A sprite wider than the screen pins to x = 0
    assign x_span = 18'(SCREEN_W) - $signed({2'b00, hi_field(char_size)});
    assign x_hi   = (x_span < 18'sd0) ? 18'sd0 : x_span;

    physics_axis u_axis_x (
        .pos        (x_q),
        .vel        (int_vx),
        .lo         (18'sd0),
        .hi         (x_hi),
        .zero_on_lo (1'b0),
        .result     (ax_res),
        .vel_out    (ax_vel)
    );

    physics_axis u_axis_y (
        .pos        (y_q),
        .vel        (int_vy),
        .lo         (18'sd0),
        .hi         (18'sh0FFFF),
        .zero_on_lo (1'b1),
        .result     (ay_res),
        .vel_out    (ay_vel)
    );

    assign is_ko   = y_q >= SCR_H;
    assign land    = coll[COLL_B] && !vy_q[7];
    assign hit_top = coll[COLL_T] && vy_q[7];
    assign side    = (coll[COLL_L] && vx_q < 8'sd0)
                  || (coll[COLL_R] && vx_q > 8'sd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= SPX; y_q <= SPY;
            px_q <= SPX; py_q <= SPY;
            vx_q <= '0; vy_q <= '0;
            grounded_q <= 1'b0;
            jumps_left <= JMAX;
            left_q <= 1'b0; right_q <= 1'b0; jreq_q <= 1'b0;
            jump_d <= 1'b0; jump_pend <= 1'b0;
            update_done <= 1'b0; ko <= 1'b0; overrun <= 1'b0;
        end else begin
            update_done <= 1'b0;
            ko          <= 1'b0;
            overrun     <= frame_tick && (state != S_IDLE);
            jump_d      <= jump_btn;
            if (state == S_IDLE && frame_tick) begin
                left_q    <= move_left;
                right_q   <= move_right;
                jreq_q    <= jump_pend | jump_rise;
                jump_pend <= 1'b0;
            end else if (jump_rise) begin
                jump_pend <= 1'b1;
            end
            case (state)
                S_INTEGRATE: begin
                    vx_q <= ax_vel;
                    vy_q <= ay_vel;
                    px_q <= x_q;
                    py_q <= y_q;
                    x_q  <= ax_res;
                    y_q  <= ay_res;
                    if (jump_ok) begin
                        jumps_left <= jumps_left - 2'd1;
                        grounded_q <= 1'b0;
                    end
                end
                S_RESOLVE: begin
                    update_done <= 1'b1;
                    if (is_ko) begin
                        x_q <= SPX; y_q <= SPY;
                        vx_q <= '0; vy_q <= '0;
                        grounded_q <= 1'b0;
                        jumps_left <= JMAX;
                        ko <= 1'b1;
                    end else begin
                        if (land) begin
                            y_q <= lo_field(stage_pos) - lo_field(char_size);
                            vy_q <= '0;
                            grounded_q <= 1'b1;
                            jumps_left <= JMAX;
                        end else if (hit_top) begin
                            y_q  <= py_q;
                            vy_q <= '0;
                        end
                        if (side) begin
                            x_q  <= px_q;
                            vx_q <= '0;
                        end
                        if (!land && grounded_q && !coll[COLL_B])
                            grounded_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign char_pos = {x_q, y_q};
    assign vel_x    = vx_q;
    assign vel_y    = vy_q;
    assign grounded = grounded_q;

endmodule
